// File: rtl/ad9516_cfg_sched.sv
// AD9516 configuration scheduler: ROM walk, IO update, PLL lock poll,
// then CPU register access, all over one shared SPI engine.
module ad9516_cfg_sched #(
  parameter int          ROM_AW        = 7,
  parameter int          SETTLE_CYCLES = 1000,
  parameter int          POLL_GAP      = 256,
  parameter int          POLL_MAX      = 16,
  parameter logic [12:0] LOCK_REG      = 13'h01F,
  parameter int          LOCK_BIT      = 0,
  parameter logic [12:0] UPDATE_REG    = 13'h232
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [23:0]       rom_data,
  input  logic              rom_end,
  output logic              spi_req,
  output logic [23:0]       spi_word,
  input  logic              spi_ack,
  input  logic              spi_done,
  input  logic [7:0]        spi_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [12:0]       cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_error,
  output logic              pll_locked
);

  localparam int TMAX =
    (SETTLE_CYCLES > POLL_GAP) ? SETTLE_CYCLES : POLL_GAP;
  localparam int TW = $clog2(TMAX + 1);
  localparam int PW = $clog2(POLL_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LATCH, S_ISSUE,
    S_WAIT_DONE, S_UPDATE, S_SETTLE, S_POLL,
    S_POLL_GAP, S_READY, S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    O_ROM, O_UPD, O_POLL, O_CPU
  } origin_t;

  state_t            state, state_d;
  origin_t           origin, origin_d;
  logic              home, home_d;
  logic [ROM_AW-1:0] rom_addr_d;
  logic              wrap, wrap_d;
  logic              spi_req_d;
  logic [23:0]       spi_word_d;
  logic              cpu_ack_d;
  logic [7:0]        cpu_rdata_d;
  logic              busy_d, cfg_done_d;
  logic              cfg_error_d, pll_locked_d;
  logic [TW-1:0]     timer, timer_d;
  logic [PW-1:0]     poll_cnt, poll_cnt_d;
  logic              pend, pend_d;
  logic              armed, armed_d;
  logic              restart;

  always_comb begin
    state_d      = state;
    origin_d     = origin;
    home_d       = home;
    rom_addr_d   = rom_addr;
    wrap_d       = wrap;
    spi_req_d    = spi_req;
    spi_word_d   = spi_word;
    cpu_ack_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata;
    busy_d       = busy;
    cfg_done_d   = cfg_done;
    cfg_error_d  = cfg_error;
    pll_locked_d = pll_locked;
    timer_d      = timer;
    poll_cnt_d   = poll_cnt;
    pend_d       = pend;
    armed_d      = armed | ~cpu_req;
    restart      = 1'b0;
    unique case (state)
      S_IDLE: restart = start;
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        if (rom_end) begin
          state_d = S_UPDATE;
        end else begin
          spi_word_d = rom_data;
          spi_req_d  = 1'b1;
          rom_addr_d = rom_addr + 1'b1;
          wrap_d     = &rom_addr;
          origin_d   = O_ROM;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (spi_ack) begin
          spi_req_d = 1'b0;
          state_d   = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (spi_done) begin
          unique case (origin)
            O_ROM: begin
              if (wrap) begin
                state_d     = S_ERROR;
                home_d      = 1'b1;
                cfg_error_d = 1'b1;
                busy_d      = 1'b0;
              end else begin
                state_d = S_FETCH;
              end
            end
            O_UPD: begin
              state_d = S_SETTLE;
              timer_d = '0;
            end
            O_POLL: begin
              pll_locked_d = spi_rdata[LOCK_BIT];
              if (spi_rdata[LOCK_BIT]) begin
                state_d    = S_READY;
                home_d     = 1'b0;
                cfg_done_d = 1'b1;
                busy_d     = 1'b0;
              end else if (poll_cnt == PW'(POLL_MAX)) begin
                state_d     = S_ERROR;
                home_d      = 1'b1;
                cfg_error_d = 1'b1;
                busy_d      = 1'b0;
              end else begin
                state_d = S_POLL_GAP;
                timer_d = '0;
              end
            end
            O_CPU: begin
              cpu_ack_d = 1'b1;
              armed_d   = 1'b0;
              if (spi_word[23])
                cpu_rdata_d = spi_rdata;
              state_d = home ? S_ERROR : S_READY;
              restart = pend | start;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_UPDATE: begin
        spi_word_d = {1'b0, 2'b00, UPDATE_REG, 8'h01};
        spi_req_d  = 1'b1;
        origin_d   = O_UPD;
        state_d    = S_ISSUE;
      end
      S_SETTLE: begin
        if (timer == TW'(SETTLE_CYCLES - 1))
          state_d = S_POLL;
        else
          timer_d = timer + 1'b1;
      end
      S_POLL: begin
        spi_word_d = {1'b1, 2'b00, LOCK_REG, 8'h00};
        spi_req_d  = 1'b1;
        poll_cnt_d = poll_cnt + 1'b1;
        origin_d   = O_POLL;
        state_d    = S_ISSUE;
      end
      S_POLL_GAP: begin
        if (timer == TW'(POLL_GAP - 1))
          state_d = S_POLL;
        else
          timer_d = timer + 1'b1;
      end
      S_READY, S_ERROR: begin
        if (start) begin
          restart = 1'b1;
        end else if (cpu_req && armed) begin
          spi_word_d = {~cpu_we, 2'b00, cpu_addr, cpu_wdata};
          spi_req_d  = 1'b1;
          origin_d   = O_CPU;
          state_d    = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A start that lands on an in-flight CPU access waits for its ack.
    if (start && origin == O_CPU &&
        state inside {S_ISSUE, S_WAIT_DONE})
      pend_d = 1'b1;
    if (restart) begin
      state_d     = S_FETCH;
      rom_addr_d  = '0;
      wrap_d      = 1'b0;
      busy_d      = 1'b1;
      cfg_done_d  = 1'b0;
      cfg_error_d = 1'b0;
      poll_cnt_d  = '0;
      pend_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      origin     <= O_ROM;
      home       <= 1'b0;
      rom_addr   <= '0;
      wrap       <= 1'b0;
      spi_req    <= 1'b0;
      spi_word   <= '0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
      busy       <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_error  <= 1'b0;
      pll_locked <= 1'b0;
      timer      <= '0;
      poll_cnt   <= '0;
      pend       <= 1'b0;
      armed      <= 1'b1;
    end else begin
      state      <= state_d;
      origin     <= origin_d;
      home       <= home_d;
      rom_addr   <= rom_addr_d;
      wrap       <= wrap_d;
      spi_req    <= spi_req_d;
      spi_word   <= spi_word_d;
      cpu_ack    <= cpu_ack_d;
      cpu_rdata  <= cpu_rdata_d;
      busy       <= busy_d;
      cfg_done   <= cfg_done_d;
      cfg_error  <= cfg_error_d;
      pll_locked <= pll_locked_d;
      timer      <= timer_d;
      poll_cnt   <= poll_cnt_d;
      pend       <= pend_d;
      armed      <= armed_d;
    end
  end

endmodule

// File: tb/tb_ad9516_cfg_sched.sv
// Bench for ad9516_cfg_sched: ROM and SPI engine models, a
// transaction-list reference model and CPU access vector table.
module tb_ad9516_cfg_sched;

  localparam int SETTLE = 1000;
  localparam int GAP    = 256;
  localparam int PMAX   = 16;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [6:0]  rom_addr;
  logic [23:0] rom_data;
  logic        rom_end;
  logic        spi_req;
  logic [23:0] spi_word;
  logic        spi_ack, spi_done;
  logic [7:0]  spi_rdata;
  logic        cpu_req, cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        busy, cfg_done, cfg_error, pll_locked;

  ad9516_cfg_sched dut (
    .clk(clk), .rst(rst), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .rom_end(rom_end), .spi_req(spi_req),
    .spi_word(spi_word), .spi_ack(spi_ack),
    .spi_done(spi_done), .spi_rdata(spi_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .busy(busy), .cfg_done(cfg_done),
    .cfg_error(cfg_error), .pll_locked(pll_locked)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int proto_err = 0;
  int ack_cnt = 0;

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (cpu_ack) ack_cnt++;
    if (cpu_ack && busy) proto_err++;
  end

  // registered ROM: data follows the address by one clock
  logic [23:0] rom_mem [128];
  bit          rom_em  [128];
  always @(posedge clk) begin
    rom_data <= rom_mem[rom_addr];
    rom_end  <= rom_em[rom_addr];
  end

  // SPI engine model
  int          ack_dly = 3;
  int          done_dly = 30;
  int          lock_after = 1;
  int          poll_no = 0;
  int          eng_phase = 0;
  logic [7:0]  cpu_resp = 8'h00;
  logic [23:0] spi_log[$];
  int          req_cyc[$];
  int          done_cyc[$];
  logic [23:0] exp_q[$];

  initial begin : engine
    logic [23:0] w;
    logic [7:0]  r;
    logic [7:0]  t;
    spi_ack = 0; spi_done = 0; spi_rdata = 0;
    forever begin
      @(negedge clk);
      if (spi_req && !rst) begin
        w = spi_word;
        spi_log.push_back(w);
        req_cyc.push_back(cyc);
        eng_phase = 1;
        for (int i = 1; i < ack_dly; i++) begin
          @(negedge clk);
          if (!rst && (!spi_req || spi_word !== w))
            proto_err++;
        end
        spi_ack = 1;
        @(negedge clk);
        spi_ack = 0;
        eng_phase = 2;
        t = 8'($urandom);
        if (w[23] && w[20:8] == 13'h01F) begin
          poll_no++;
          r = t;
          r[0] = (poll_no >= lock_after);
        end else if (w[23]) begin
          r = cpu_resp;
        end else begin
          r = t;
        end
        for (int i = 1; i < done_dly; i++) begin
          @(negedge clk);
          if (spi_req && !rst) proto_err++;
        end
        spi_rdata = r;
        spi_done = 1;
        done_cyc.push_back(cyc);
        @(negedge clk);
        spi_done = 0;
        eng_phase = 0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               name, act, exp);
    end
  endtask

  task automatic set_rom(int n);
    for (int i = 0; i < 128; i++) begin
      rom_mem[i] = 24'($urandom) & 24'h7FFFFF;
      rom_em[i]  = (i == n);
    end
  endtask

  // reference: ROM words, IO update, then polls until lock or limit
  task automatic build_exp(int n);
    int k;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(rom_mem[i]);
    exp_q.push_back(24'h023201);
    k = (lock_after <= PMAX) ? lock_after : PMAX;
    repeat (k) exp_q.push_back(24'h801F00);
  endtask

  task automatic check_seq(string name);
    int bad;
    int m;
    bad = -1;
    m = (spi_log.size() < exp_q.size()) ?
        spi_log.size() : exp_q.size();
    tests++;
    for (int i = 0; i < m; i++)
      if (bad < 0 && spi_log[i] !== exp_q[i]) bad = i;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s: word %0d got 0x%06h, expected 0x%06h",
               name, bad, spi_log[bad], exp_q[bad]);
    end else if (spi_log.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s: got %0d transactions, expected %0d",
               name, spi_log.size(), exp_q.size());
    end
  endtask

  task automatic clear_log();
    spi_log.delete();
    req_cyc.delete();
    done_cyc.delete();
    poll_no = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic wait_cfg(string name, int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles",
               name, n);
    end
  endtask

  task automatic cpu_access(bit we, logic [12:0] a,
                            logic [7:0] wd, logic [7:0] resp,
                            output logic [7:0] rd,
                            output logic [23:0] wlog,
                            output bit ok);
    int n;
    cpu_resp = resp;
    cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    cpu_req = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_ack && n < 3000);
    ok = cpu_ack;
    rd = cpu_rdata;
    wlog = (spi_log.size() > 0) ? spi_log[$] : 24'hx;
    cpu_req = 0;
    @(negedge clk);
    check("ack_pulse_width", cpu_ack, 0);
  endtask

  task automatic run_cfg(string name, int n, bit exp_ok);
    clear_log();
    build_exp(n);
    pulse_start();
    wait_cfg(name, 20000);
    check_seq({name, "_seq"});
    check({name, "_flags"},
          {busy, cfg_done, cfg_error, pll_locked},
          {1'b0, exp_ok, !exp_ok, exp_ok});
  endtask

  typedef struct {
    bit          we;
    logic [12:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  resp;
    logic [23:0] exp_word;
    logic [7:0]  exp_rdata;
  } vec_t;

  initial begin
    vec_t        tbl[6];
    logic [7:0]  rd;
    logic [23:0] wl;
    bit          ok;
    int          n, gmin, gmax, a0, nr, la;

    tbl[0] = '{1, 13'h0232, 8'h01, 8'h00, 24'h023201, 8'h5A};
    tbl[1] = '{0, 13'h0000, 8'h00, 8'h18, 24'h800000, 8'h18};
    tbl[2] = '{1, 13'h0010, 8'h7C, 8'h00, 24'h00107C, 8'h18};
    tbl[3] = '{0, 13'h1FFF, 8'h00, 8'hA5, 24'h9FFF00, 8'hA5};
    tbl[4] = '{0, 13'h0123, 8'h33, 8'hC3, 24'h812333, 8'hC3};
    tbl[5] = '{1, 13'h00AB, 8'hFF, 8'h00, 24'h00ABFF, 8'hC3};

    rst = 1; start = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    set_rom(2);
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("reset_outputs",
          {rom_addr, spi_req, spi_word, cpu_ack, cpu_rdata,
           busy, cfg_done, cfg_error, pll_locked}, 64'h0);

    // 1: two ROM words, lock on first poll
    rom_mem[0] = 24'h000018;
    rom_mem[1] = 24'h001000;
    lock_after = 1;
    run_cfg("t1", 2, 1);
    check("t1_count", spi_log.size(), 4);

    // 2: lock never seen
    lock_after = 1000;
    run_cfg("t2", 2, 0);
    gmin = 1 << 30; gmax = 0;
    for (int i = 4; i < spi_log.size(); i++) begin
      n = req_cyc[i] - done_cyc[i - 1];
      if (n < gmin) gmin = n;
      if (n > gmax) gmax = n;
    end
    check("t2_gap_min_ok", gmin >= GAP + 1, 1);
    check("t2_gap_max_ok", gmax <= GAP + 3, 1);
    n = req_cyc[3] - done_cyc[2];
    check("t2_settle_ok", n >= SETTLE + 1 && n <= SETTLE + 3, 1);

    // 3: CPU read requested during configuration is stalled
    lock_after = 1;
    clear_log();
    pulse_start();
    repeat (20) @(negedge clk);
    a0 = ack_cnt;
    cpu_resp = 8'h5A;
    cpu_we = 0; cpu_addr = 13'h0F0; cpu_wdata = 0;
    cpu_req = 1;
    wait_cfg("t3", 20000);
    check("t3_no_ack_while_busy", ack_cnt - a0, 0);
    check("t3_cfg_done", cfg_done, 1);
    cpu_access(0, 13'h0F0, 8'h00, 8'h5A, rd, wl, ok);
    check("t3_ack", ok, 1);
    check("t3_word", wl, 24'h80F000);
    check("t3_rdata", rd, 8'h5A);

    // 4: table of CPU accesses in READY
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cpu_access(tbl[i].we, tbl[i].addr, tbl[i].wdata,
                 tbl[i].resp, rd, wl, ok);
      check($sformatf("tbl%0d_ack", i), ok, 1);
      check($sformatf("tbl%0d_word", i), wl, tbl[i].exp_word);
      check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
    end

    // 5: reset while word 5 awaits its done
    set_rom(8);
    clear_log();
    pulse_start();
    n = 0;
    while (!(spi_log.size() == 5 && eng_phase == 2) && n < 5000)
    begin
      @(negedge clk);
      n++;
    end
    check("t5_reached_word5", n < 5000, 1);
    rst = 1;
    @(negedge clk);
    check("t5_reset_outputs",
          {rom_addr, spi_req, spi_word, cpu_ack, cpu_rdata,
           busy, cfg_done, cfg_error, pll_locked}, 64'h0);
    rst = 0;
    repeat (60) @(negedge clk);
    check("t5_idle_after_stray_done",
          {busy, spi_req, 8'(spi_log.size())}, {2'b00, 8'd5});
    lock_after = 2;
    run_cfg("t5_replay", 8, 1);

    // 6: start and cpu_req together in READY
    clear_log();
    build_exp(8);
    a0 = ack_cnt;
    cpu_resp = 8'h66;
    cpu_we = 0; cpu_addr = 13'h055; cpu_wdata = 0;
    @(negedge clk);
    start = 1; cpu_req = 1;
    @(negedge clk);
    start = 0;
    check("t6_busy", busy, 1);
    wait_cfg("t6", 20000);
    check_seq("t6_seq");
    check("t6_no_ack_during_cfg", ack_cnt - a0, 0);
    cpu_access(0, 13'h055, 8'h00, 8'h66, rd, wl, ok);
    check("t6_word", wl, 24'h805500);
    check("t6_rdata", rd, 8'h66);

    // randomized configurations against the reference model
    for (int r = 0; r < 4; r++) begin
      nr = $urandom_range(1, 12);
      la = $urandom_range(1, 19);
      ack_dly = $urandom_range(1, 5);
      done_dly = $urandom_range(2, 20);
      lock_after = la;
      set_rom(nr);
      run_cfg($sformatf("rnd%0d", r), nr, la <= PMAX);
    end

    // ROM without end marker wraps into error
    ack_dly = 1; done_dly = 2;
    set_rom(200);
    clear_log();
    pulse_start();
    wait_cfg("wrap", 20000);
    check("wrap_len", spi_log.size(), 128);
    check("wrap_flags", {busy, cfg_done, cfg_error}, 3'b001);

    check("protocol_errors", proto_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
